// File: rtl/pixel_scan_ctrl.sv
// Raster scan sequencer: steps x/y through the real2imag converter and hands each pixel to the iteration engine.
// Optional CONVERT watchdog (timeout_err) is built only when PIXEL_SCAN_TIMEOUT_EN is defined.
module pixel_scan_ctrl #(
  parameter int H_PIXELS = 640,
  parameter int V_PIXELS = 480,
  parameter int WIDTH    = 22,
  parameter int TIMEOUT  = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic                    abort,
  output logic                    frame_busy,
  output logic                    frame_done,
  output logic [9:0]              conv_x,
  output logic [9:0]              conv_y,
  output logic                    convert_start,
  input  logic                    convert_done,
  input  logic signed [WIDTH-1:0] z_real_in,
  input  logic signed [WIDTH-1:0] z_imag_in,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic [9:0]              pix_x,
  output logic [9:0]              pix_y,
  output logic signed [WIDTH-1:0] pix_z_real,
  output logic signed [WIDTH-1:0] pix_z_imag,
  output logic                    pix_last,
  output logic                    timeout_err
);

  localparam logic [9:0] X_LAST = 10'(H_PIXELS - 1);
  localparam logic [9:0] Y_LAST = 10'(V_PIXELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_PRESENT, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_first;
  logic [9:0]              r_x;
  logic [9:0]              r_y;
  logic [9:0]              r_pix_x;
  logic [9:0]              r_pix_y;
  logic signed [WIDTH-1:0] r_pix_zr;
  logic signed [WIDTH-1:0] r_pix_zi;
  logic                    r_timeout_err;
  logic                    w_start;
  logic                    w_accept;
  logic                    w_hs;
  logic                    w_last;
  logic                    w_enter_conv;
  logic                    w_timeout;

  assign w_start      = (r_state == S_IDLE) && frame_start;
  // The converter's done flag may be stale on the first CONVERT cycle of a pixel.
  assign w_accept     = (r_state == S_CONVERT) && !r_first && convert_done;
  assign w_hs         = (r_state == S_PRESENT) && pix_ready;
  assign w_last       = (r_pix_x == X_LAST) && (r_pix_y == Y_LAST);
  assign w_enter_conv = (w_next == S_CONVERT) && (r_state != S_CONVERT);

`ifdef PIXEL_SCAN_TIMEOUT_EN
  localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TCW-1:0] r_tcnt;

  assign w_timeout = (r_state == S_CONVERT) && !w_accept && (r_tcnt == TCW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt <= '0;
    end else if (w_enter_conv) begin
      r_tcnt <= '0;
    end else if (r_state == S_CONVERT) begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_timeout        = 1'b0;
  assign w_unused_timeout = (TIMEOUT > 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (frame_start) w_next = S_CONVERT;
      end
      S_CONVERT: begin
        if (w_timeout) w_next = S_IDLE;
        else if (w_accept) w_next = S_PRESENT;
      end
      S_PRESENT: begin
        if (pix_ready) w_next = w_last ? S_DONE : S_CONVERT;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (abort && (r_state != S_IDLE)) w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_first       <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_pix_x       <= '0;
      r_pix_y       <= '0;
      r_pix_zr      <= '0;
      r_pix_zi      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_first <= w_enter_conv;
      if (w_start) begin
        r_x <= '0;
        r_y <= '0;
      end else if (w_hs && !abort && !w_last) begin
        if (r_x == X_LAST) begin
          r_x <= '0;
          r_y <= r_y + 10'd1;
        end else begin
          r_x <= r_x + 10'd1;
        end
      end
      if (w_accept && !abort) begin
        r_pix_x  <= r_x;
        r_pix_y  <= r_y;
        r_pix_zr <= z_real_in;
        r_pix_zi <= z_imag_in;
      end
      if (w_start) begin
        r_timeout_err <= 1'b0;
      end else if (w_timeout && !abort) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign frame_busy    = (r_state != S_IDLE);
  assign frame_done    = (r_state == S_DONE);
  assign convert_start = (r_state == S_CONVERT);
  assign pix_valid     = (r_state == S_PRESENT);
  assign pix_last      = (r_state == S_PRESENT) && w_last;
  assign conv_x        = r_x;
  assign conv_y        = r_y;
  assign pix_x         = r_pix_x;
  assign pix_y         = r_pix_y;
  assign pix_z_real    = r_pix_zr;
  assign pix_z_imag    = r_pix_zi;
  assign timeout_err   = r_timeout_err;

endmodule
